// File: rtl/lu_serial_acc_pkg.sv
// ============================================================================
// Module   : lu_pkg
// Brief    : Op codes and FSM state encoding shared by the serial logic unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lu_pkg;

  localparam logic [2:0] LU_AND   = 3'b000;
  localparam logic [2:0] LU_NAND  = 3'b001;
  localparam logic [2:0] LU_OR    = 3'b010;
  localparam logic [2:0] LU_NOR   = 3'b011;
  localparam logic [2:0] LU_XOR   = 3'b100;
  localparam logic [2:0] LU_XNOR  = 3'b101;
  localparam logic [2:0] LU_NOTA  = 3'b110;
  localparam logic [2:0] LU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lu_state_t;

endpackage

`default_nettype wire

// File: rtl/lu_serial_acc_slice.sv
// ============================================================================
// Module   : lu_slice
// Brief    : Combinational SLICE-bit logic unit, eight bitwise operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lu_slice
  import lu_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] s
);

  always_comb begin
    s = '0;
    case (op)
      LU_AND:   s = a & b;
      LU_NAND:  s = ~(a & b);
      LU_OR:    s = a | b;
      LU_NOR:   s = ~(a | b);
      LU_XOR:   s = a ^ b;
      LU_XNOR:  s = ~(a ^ b);
      LU_NOTA:  s = ~a;
      default:  s = b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lu_serial_acc.sv
// ============================================================================
// Module   : lu_serial_acc
// Brief    : WIDTH-bit logic unit processed SLICE bits per clock, LSB first,
//            with a result accumulator usable as operand B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lu_serial_acc
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] acc,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_last = CW'(N - 1);

  lu_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;

  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_res_next;

  lu_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (r_opa[SLICE-1:0]),
    .b  (r_opb[SLICE-1:0]),
    .op (r_op),
    .s  (w_slice)
  );

  // Slices enter from the MSB side so the LSB slice lands at bit 0 after N shifts.
  generate
    if (SLICE == WIDTH) begin : g_single
      assign w_res_next = w_slice;
    end else begin : g_multi
      assign w_res_next = {w_slice, r_res[WIDTH-1:SLICE]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= use_acc ? r_s : b;
            r_op    <= op;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_res <= w_res_next;
          r_opa <= r_opa >> SLICE;
          r_opb <= r_opb >> SLICE;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            r_s     <= w_res_next;
            r_zero  <= (w_res_next == '0);
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The accumulator is by definition the last completed result.
  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign acc  = r_s;
  assign zero = r_zero;

endmodule

`default_nettype wire

// File: doc/lu_serial_acc.md
Name: lu_serial_acc

Overview:
- Parametrised successor to the 1-bit gate-level logic unit: WIDTH-bit logic unit with 8 selectable operations.
- Processes SLICE bits per clock, LSB first, under a start/busy/done handshake.
- Writes each result to an accumulator register, which can be fed back as operand B for chained operations.
- Sits beside the arithmetic blocks as the logic datapath of the upcoming small CPU exercises.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of SLICE.
SLICE, 2, bits processed per cycle; N = WIDTH/SLICE cycles per operation.

Ports:
clk  input  1  single rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  3  operation code, latched with start.
use_acc  input  1  1 = operand B taken from acc, 0 = from b; latched with start.
a  input  WIDTH  operand A, latched with start.
b  input  WIDTH  operand B, latched with start.
busy  output  1  high while state != IDLE.
done  output  1  one-cycle pulse when s/acc are updated.
s  output  WIDTH  registered result of the last completed operation.
acc  output  WIDTH  accumulator; equals s after each completion.
zero  output  1  registered flag, 1 when the last result == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values (immediate, async):
  - state = IDLE; s = 0; acc = 0.
  - zero = 1; busy = 0; done = 0.
  - slice counter = 0; internal operand and result shift registers = 0.
- Op codes, applied bitwise:
  - 000 AND, 001 NAND, 010 OR, 011 NOR.
  - 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS B (A ignored).
- IDLE:
  - On an edge with start=1, latch opA = a, opB = (use_acc ? acc : b), op.
  - Clear the counter and go to BUSY.
  - start=0 keeps the FSM in IDLE.
- BUSY:
  - Each edge: compute the low SLICE bits of opA/opB with the latched op.
  - Shift that slice into the result register from the MSB side.
  - Shift opA/opB right by SLICE; increment the counter.
  - On the edge that processes slice N-1, write the complete result to s and acc, update zero, go to DONE.
- DONE:
  - done = 1 for exactly that cycle; busy still 1.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - start sampled at edge k.
  - Result visible on s/acc and done high from edge k+N to edge k+N+1.
  - Next start is accepted at edge k+N+2 at the earliest.
- Boundary conditions:
  - start asserted in BUSY or DONE is ignored, with no queuing.
  - Changes on a/b/op/use_acc after the start edge have no effect on the current operation.
  - use_acc=1 uses the acc value present at the start edge.
  - Reset mid-operation aborts: no done pulse, and s/acc return to 0.
  - SLICE == WIDTH gives N=1: one BUSY cycle, done at k+1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package lu_pkg holds:
  - the op-code localparams (LU_AND … LU_PASSB);
  - the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One natural sub-module, lu_slice: combinational SLICE-bit logic unit (inputs a, b, op; output s), instantiated once inside lu_serial_acc.
- FSM, counter and shift registers stay in the top module.

Test Plan (WIDTH=8, SLICE=2, N=4):
1. Assert reset mid-simulation -> s=8'h00, acc=8'h00, zero=1, busy=0, done=0 immediately, without waiting for a clk edge.
2. a=8'hF0, b=8'h3C, op=AND, use_acc=0, start pulse at edge k:
   - busy=1 from edge k through edge k+5;
   - done=1 only between edges k+4 and k+5;
   - s=acc=8'h30, zero=0.
3. Same operands with op=NOR -> s=8'h03; then op=NOT A with a=8'hA5 -> s=8'h5A; then op=PASS B with b=8'h81 -> s=8'h81.
4. Accumulator chaining: with acc=8'h03, run a=8'h03, op=XOR, use_acc=1 -> s=acc=8'h00, zero=1. Then a=8'hFF, op=XNOR, use_acc=1 -> s=8'h00? No: XNOR(FF,00)=8'h00, zero=1.
5. Start at edge k; at k+2 change a to 8'h00 and pulse start again -> first result unchanged (per scenario 2); no second done; FSM returns to IDLE at k+5.
6. Reset asserted between edges k+2 and k+3 of an operation -> busy=0, s=acc=0, zero=1; no done pulse. A fresh start after reset release completes normally.
